// File: rtl/cpu_defs.sv
// Shared control/DataPath definitions: opcodes, ALU operation codes,
// T-state encoding and instruction-register field positions.
package cpu_defs;

    // Instruction register layout
    localparam int IR_W    = 32;
    localparam int OPC_LSB = 27;   // opcode = IR[31:27]
    localparam int RA_LSB  = 23;   // Ra     = IR[26:23]
    localparam int RB_LSB  = 19;   // Rb     = IR[22:19]
    localparam int RC_LSB  = 15;   // Rc     = IR[18:15]
    localparam int REG_W   = 4;    // register-select field width

    // Opcodes
    localparam logic [4:0] OPC_ADD  = 5'b00000;
    localparam logic [4:0] OPC_SUB  = 5'b00001;
    localparam logic [4:0] OPC_AND  = 5'b00010;
    localparam logic [4:0] OPC_OR   = 5'b00011;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NOP  = 5'b11001;
    localparam logic [4:0] OPC_HALT = 5'b11010;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;

    // Sequencer T-states
    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } tstate_e;

    // Instruction classes that share an execute sequence
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_e;

    function automatic instr_class_e decode_class(input logic [4:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: return CLS_ALU;
            OPC_MUL, OPC_DIV:                  return CLS_MULDIV;
            OPC_NOP:                           return CLS_NOP;
            OPC_HALT:                          return CLS_HALT;
            default:                           return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [3:0] alu_op_of(input logic [4:0] opc);
        case (opc)
            OPC_SUB: return ALU_SUB;
            OPC_AND: return ALU_AND;
            OPC_OR:  return ALU_OR;
            OPC_MUL: return ALU_MUL;
            OPC_DIV: return ALU_DIV;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Binary-to-one-hot register select with enable; all zeros when disabled.
module reg_select_decoder #(
    parameter int NREG  = 16,
    parameter int SEL_W = $clog2(NREG)
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [NREG-1:0]  onehot_o
);

    // One-hot decode of the selected register
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/instr_control_sequencer.sv
// Hardwired control unit: steps fetch/decode/execute T-states and drives
// every DataPath strobe as a combinational decode of state and IR.
module instr_control_sequencer
    import cpu_defs::*;
#(
    parameter int OPC_W = 5,
    parameter int NREG  = 16
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic [IR_W-1:0]  IR,
    input  logic             mem_ready,
    output logic             PCout,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIout,
    output logic             LOout,
    output logic             MDRout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin_low,
    output logic             Zin_high,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic [NREG-1:0]  Rout,
    output logic [NREG-1:0]  Rin,
    output logic [3:0]       operation,
    output logic             Run,
    output logic             illegal_op
);

    tstate_e          state_q, state_d;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] ra, rb, rc;
    instr_class_e     iclass;
    logic             rout_en, rin_en;
    logic [REG_W-1:0] rout_sel, rin_sel;
    logic             unused_ir_low;

    assign opcode        = IR[OPC_LSB +: OPC_W];
    assign ra            = IR[RA_LSB +: REG_W];
    assign rb            = IR[RB_LSB +: REG_W];
    assign rc            = IR[RC_LSB +: REG_W];
    assign unused_ir_low = ^IR[RC_LSB-1:0];
    assign iclass        = decode_class(opcode);

    // Next T-state: T1 waits on mem_ready, execute length depends on class
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_T0: state_d = ST_T1;
            ST_T1: if (mem_ready) state_d = ST_T2;
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                case (iclass)
                    CLS_ALU, CLS_MULDIV: state_d = ST_T4;
                    CLS_HALT:            state_d = ST_HALT;
                    default:             state_d = ST_T0;
                endcase
            end
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = (iclass == CLS_MULDIV) ? ST_T6 : ST_T0;
            ST_T6:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_T0;
        endcase
    end

    // T-state register
    // NOTE: only the state register is reset; outputs are gated by clear
    // below, so they drop asynchronously without needing reset flops.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_T0;
        end else begin
            // NOTE: non-blocking so the register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Strobe decode of the current T-state and IR, forced low during clear
    // NOTE: every output gets a default first, so no path infers a latch.
    always_comb begin
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin_low    = 1'b0;
        Zin_high   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        rout_en    = 1'b0;
        rout_sel   = '0;
        rin_en     = 1'b0;
        rin_sel    = '0;
        operation  = ALU_ADD;
        illegal_op = 1'b0;
        if (clear) begin
            case (state_q)
                ST_T0: begin
                    PCout   = 1'b1;
                    MARin   = 1'b1;
                    IncPC   = 1'b1;
                    Zin_low = 1'b1;
                end
                ST_T1: begin
                    Zlowout = 1'b1;
                    Read    = 1'b1;
                    if (mem_ready) begin
                        MDRin = 1'b1;
                        PCin  = 1'b1;
                    end
                end
                ST_T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                ST_T3: begin
                    case (iclass)
                        CLS_ALU: begin
                            rout_en  = 1'b1;
                            rout_sel = rb;
                            Yin      = 1'b1;
                        end
                        CLS_MULDIV: begin
                            rout_en  = 1'b1;
                            rout_sel = ra;
                            Yin      = 1'b1;
                        end
                        CLS_ILLEGAL: illegal_op = 1'b1;
                        default: ;
                    endcase
                end
                ST_T4: begin
                    case (iclass)
                        CLS_ALU: begin
                            rout_en   = 1'b1;
                            rout_sel  = rc;
                            operation = alu_op_of(opcode);
                            Zin_low   = 1'b1;
                        end
                        CLS_MULDIV: begin
                            rout_en   = 1'b1;
                            rout_sel  = rb;
                            operation = alu_op_of(opcode);
                            Zin_low   = 1'b1;
                            Zin_high  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_T5: begin
                    case (iclass)
                        CLS_ALU: begin
                            Zlowout = 1'b1;
                            rin_en  = 1'b1;
                            rin_sel = ra;
                        end
                        CLS_MULDIV: begin
                            Zlowout = 1'b1;
                            LOin    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_T6: begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Run = (state_q != ST_HALT);

    reg_select_decoder #(.NREG(NREG), .SEL_W(REG_W)) u_rout_dec (
        .sel_i    (rout_sel),
        .en_i     (rout_en),
        .onehot_o (Rout)
    );

    reg_select_decoder #(.NREG(NREG), .SEL_W(REG_W)) u_rin_dec (
        .sel_i    (rin_sel),
        .en_i     (rin_en),
        .onehot_o (Rin)
    );

endmodule

// File: tb/tb_instr_control_sequencer.sv
// Scoreboard bench for instr_control_sequencer: the stimulus process expands
// each instruction into its expected per-cycle output pattern and queues it;
// a monitor on the falling edge pops and compares against the DUT.
module tb_instr_control_sequencer;

    typedef struct packed {
        logic        pc_out, zlow_out, zhigh_out, hi_out, lo_out, mdr_out;
        logic        mar_in, pc_in, mdr_in, ir_in, y_in, zin_low, zin_high;
        logic        hi_in, lo_in, inc_pc, read;
        logic [15:0] rout, rin;
        logic [3:0]  op;
        logic        run, illegal;
    } exp_t;

    logic        Clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] IR = '0;
    logic        mem_ready = 1'b0;
    logic PCout, Zlowout, Zhighout, HIout, LOout, MDRout;
    logic MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin, IncPC, Read;
    logic [15:0] Rout, Rin;
    logic [3:0]  operation;
    logic        Run, illegal_op;

    exp_t act;
    exp_t exp_q[$];
    exp_t plan[$];
    int   n_compared = 0;
    int   n_failed   = 0;
    int   cyc        = 0;

    instr_control_sequencer #(.OPC_W(5), .NREG(16)) dut (
        .Clock(Clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout),
        .LOout(LOout), .MDRout(MDRout), .MARin(MARin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin_low(Zin_low),
        .Zin_high(Zin_high), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
        .Read(Read), .Rout(Rout), .Rin(Rin), .operation(operation),
        .Run(Run), .illegal_op(illegal_op)
    );

    always #5 Clock = ~Clock;

    assign act = {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, MARin, PCin,
                  MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin, IncPC, Read,
                  Rout, Rin, operation, Run, illegal_op};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_compared++;
        if (got !== want) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic exp_t quiet(input logic run);
        exp_t e = '0;
        e.run = run;
        return e;
    endfunction

    function automatic logic [3:0] ref_op(input logic [4:0] opc);
        case (opc)
            5'd0:    return 4'b0000;
            5'd1:    return 4'b0001;
            5'd2:    return 4'b0100;
            5'd3:    return 4'b0101;
            5'd15:   return 4'b0010;
            5'd16:   return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {opc, ra, rb, rc, 15'($urandom())};
    endfunction

    // Reference: the per-cycle output pattern of one instruction
    task automatic build_plan(input logic [31:0] ir, input int waits);
        exp_t e;
        logic [4:0] opc = ir[31:27];
        int ra = int'(ir[26:23]);
        int rb = int'(ir[22:19]);
        int rc = int'(ir[18:15]);
        plan.delete();
        e = quiet(1); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.zin_low = 1;
        plan.push_back(e);
        for (int w = 0; w < waits; w++) begin
            e = quiet(1); e.zlow_out = 1; e.read = 1;
            plan.push_back(e);
        end
        e = quiet(1); e.zlow_out = 1; e.read = 1; e.mdr_in = 1; e.pc_in = 1;
        plan.push_back(e);
        e = quiet(1); e.mdr_out = 1; e.ir_in = 1;
        plan.push_back(e);
        case (opc)
            5'd0, 5'd1, 5'd2, 5'd3: begin
                e = quiet(1); e.rout = 16'h1 << rb; e.y_in = 1; plan.push_back(e);
                e = quiet(1); e.rout = 16'h1 << rc; e.op = ref_op(opc); e.zin_low = 1;
                plan.push_back(e);
                e = quiet(1); e.zlow_out = 1; e.rin = 16'h1 << ra; plan.push_back(e);
            end
            5'd15, 5'd16: begin
                e = quiet(1); e.rout = 16'h1 << ra; e.y_in = 1; plan.push_back(e);
                e = quiet(1); e.rout = 16'h1 << rb; e.op = ref_op(opc);
                e.zin_low = 1; e.zin_high = 1; plan.push_back(e);
                e = quiet(1); e.zlow_out = 1; e.lo_in = 1; plan.push_back(e);
                e = quiet(1); e.zhigh_out = 1; e.hi_in = 1; plan.push_back(e);
            end
            5'd25, 5'd26: plan.push_back(quiet(1));
            default: begin
                e = quiet(1); e.illegal = 1; plan.push_back(e);
            end
        endcase
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Drive one instruction; abort_at >= 0 pulses clear at that cycle, -2 picks one at random
    task automatic run_instr(input logic [31:0] ir, input int waits, input int abort_at);
        int ab = abort_at;
        build_plan(ir, waits);
        if (ab == -2) ab = $urandom_range(0, plan.size() - 1);
        for (int i = 0; i < plan.size(); i++) begin
            if (i == ab) begin
                clear = 1'b0;
                exp_q.push_back(quiet(1));
                tick();
                exp_q.push_back(quiet(1));
                tick();
                clear = 1'b1;
                return;
            end
            IR = (i >= waits + 3) ? ir : 32'($urandom());
            if (i >= 1 && i <= waits) mem_ready = 1'b0;
            else if (i == waits + 1)  mem_ready = 1'b1;
            else                      mem_ready = 1'($urandom_range(0, 1));
            exp_q.push_back(plan[i]);
            tick();
        end
    endtask

    // Monitor: compare every cycle that has a queued expectation
    always @(negedge Clock) begin : monitor
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("cycle%0d outputs", cyc), 64'(act), 64'(e));
            check($sformatf("cycle%0d single_bus_driver", cyc),
                  64'(($countones({PCout, Zlowout, Zhighout, HIout, LOout, MDRout})
                       + $countones(Rout)) <= 1), 64'd1);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [4:0] legal[7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd15, 5'd16, 5'd25};
        logic [4:0] opc;
        tick();
        // Reset held: all strobes low, Run high
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            exp_q.push_back(quiet(1));
            tick();
        end
        clear = 1'b1;

        run_instr(32'h0189_0000, 0, -1);                       // add R3,R1,R2
        run_instr(32'h7B38_0000, 0, -1);                       // mul R6,R7
        run_instr(mk_ir(5'd1, 4'd2, 4'd2, 4'd2), 3, -1);       // sub, Ra=Rb=Rc, 3 waits
        run_instr(mk_ir(5'd21, 4'd5, 4'd6, 4'd7), 0, -1);      // undefined opcode
        run_instr(mk_ir(5'd25, 4'd0, 4'd0, 4'd0), 1, -1);      // nop
        run_instr(mk_ir(5'd16, 4'd9, 4'd12, 4'd0), 0, 4);      // div, clear in T4
        run_instr(mk_ir(5'd3, 4'd15, 4'd0, 4'd8), 2, -1);      // or after abort
        run_instr(mk_ir(5'd16, 4'd1, 4'd14, 4'd3), 0, -1);     // div full

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                do opc = 5'($urandom_range(0, 31));
                while (opc inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd15, 5'd16, 5'd25, 5'd26});
            end else begin
                opc = legal[$urandom_range(0, 6)];
            end
            run_instr(mk_ir(opc, 4'($urandom()), 4'($urandom()), 4'($urandom())),
                      $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? -2 : -1);
        end

        // HALT: sticky with Run low until clear
        run_instr(mk_ir(5'd26, 4'd0, 4'd0, 4'd0), 0, -1);
        for (int i = 0; i < 20; i++) begin
            IR = $urandom();
            mem_ready = 1'($urandom_range(0, 1));
            exp_q.push_back(quiet(0));
            tick();
        end
        clear = 1'b0;
        exp_q.push_back(quiet(1));
        tick();
        clear = 1'b1;
        run_instr(32'h0189_0000, 0, -1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clock);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/instr_control_sequencer.md
Name: instr_control_sequencer

Overview:
- Hardwired control unit directly upstream of the DataPath.
- Steps fetch/decode/execute T-states and drives every DataPath strobe; replaces hand-sequenced testbench stimulus.
- Supports three-register ALU ops, two-register MUL/DIV (result to HI/LO), NOP and HALT.
- Fetch waits on a memory-ready handshake.

Parameters:
- OPC_W, 5, opcode field width (IR[31:27]).
- NREG, 16, register count; Rin/Rout one-hot width.

Ports:
- Clock  in  1  system clock, rising edge.
- clear  in  1  reset; asynchronous, active-low.
- IR  in  32  instruction register contents from DataPath; fields opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- mem_ready  in  1  memory data valid; sampled only in T1.
- PCout, Zlowout, Zhighout, HIout, LOout, MDRout  out  1 each  bus-drive strobes.
- MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin, IncPC, Read  out  1 each  load/control strobes.
- Rout  out  NREG  one-hot register bus drive.
- Rin  out  NREG  one-hot register load.
- operation  out  4  ALU op: ADD 0000, SUB 0001, MUL 0010, DIV 0011, AND 0100, OR 0101.
- Run  out  1  high unless halted.
- illegal_op  out  1  one-cycle pulse on undefined opcode.

Behaviour:
- Reset (clear=0, async): state=T0. All strobes, Rin and Rout are 0. operation=0000, Run=1, illegal_op=0.
- Outputs are combinational decode of the registered state and IR.
- Strobes are valid for the whole cycle and act at the next rising edge.
- States: T0, T1, T2, T3, T4, T5, T6, HALT. Every state lasts 1 cycle except T1.
- T0: PCout, MARin, IncPC, Zin_low -> T1.
- T1: Zlowout, Read held while mem_ready=0 (stay in T1).
  - Cycle with mem_ready=1: additionally MDRin, PCin -> T2.
  - PCin fires exactly once per fetch.
- T2: MDRout, IRin -> T3. IR is decoded from T3 onward.
- ALU class (opcodes ADD=00000, SUB=00001, AND=00010, OR=00011):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], operation=op, Zin_low.
  - T5: Zlowout, Rin[Ra] -> T0.
  - Total 6 cycles with zero wait.
- MUL=01111, DIV=10000:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], operation, Zin_low, Zin_high.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin -> T0.
  - Total 7 cycles.
- NOP=11001: T3 asserts nothing -> T0.
- HALT=11010: T3 -> HALT state; Run=0, all strobes 0. HALT is sticky until clear.
- Any other opcode: illegal_op=1 during T3, nothing else asserted -> T0 (treated as NOP).
- operation holds 0000 outside T4.
- Rin/Rout are never multi-hot and never asserted outside their listed states.
- Never assert two bus drivers (any *out, Rout) in the same cycle.
- mem_ready outside T1 is ignored.
- clear asserted mid-instruction: immediate return to T0 with all outputs 0.
  - No partial register write occurs, because Rin is combinational from state.
- Ra=Rb=Rc: legal; sequence unchanged.

Decomposition:
- Shared package `cpu_defs`:
  - opcode localparams (OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_MUL, OPC_DIV, OPC_NOP, OPC_HALT);
  - ALU operation codes;
  - T-state encodings;
  - IR field bit positions.
- The DataPath and benches import the same package.
- One natural sub-module: `reg_select_decoder`, a 4-to-16 one-hot decoder with enable, instantiated twice (Rin, Rout).

Test Plan:
- Reset then IR=0x01890000 (add R3,R1,R2), mem_ready tied 1:
  - T0..T5 in 6 cycles;
  - T3 Rout=0x0002 with Yin;
  - T4 Rout=0x0004, operation=0000;
  - T5 Rin=0x0008 with Zlowout;
  - then back to T0.
- IR=0x7B380000 (mul R6,R7):
  - T3 Rout=0x0040;
  - T4 Rout=0x0080, operation=0010, Zin_low=Zin_high=1;
  - T5 LOin;
  - T6 HIin;
  - 7 cycles total.
- mem_ready low for 3 cycles in T1:
  - Read/Zlowout high for 4 cycles;
  - PCin and MDRin high only on the 4th;
  - T2 follows.
- IR opcode=11010 (HALT):
  - Run falls after T3; all strobes stay 0 for 20 cycles;
  - pulse clear low -> T0 with Run=1.
- IR opcode=10101 (undefined):
  - illegal_op high exactly one cycle in T3; no Rin/Rout activity;
  - next fetch starts.
- clear pulsed low during T4 of a DIV:
  - all outputs 0 asynchronously; LOin/HIin never asserted;
  - fetch resumes at T0 after release.
